// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo buffer.
// Optional build macro: UART_ECHO_CASE_FOLD_EN (enables fold_case on RX push).
package uart_echo_pkg;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_BUSY = 2'd2
  } tx_state_e;

  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

  // Widths for the default 16-entry buffer; use the functions for other depths.
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned LEVEL_W        = $clog2(FIFO_DEPTH_DEF + 1);
  localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH_DEF);

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // ASCII lower-case letters become upper-case; everything else passes through.
  function automatic logic [7:0] fold_case(input logic [7:0] d);
    if (d >= ASCII_LOWER_A && d <= ASCII_LOWER_Z) return d & 8'hDF;
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word (rdata always shows the
// oldest entry while not empty). Push on full and pop on empty are ignored.
module sync_fifo
  import uart_echo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  push,
  input  logic                                  pop,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  output logic [DATA_WIDTH-1:0]                 rdata,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       level
);

  localparam int unsigned PW = ptr_w(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_next;
  logic                  do_push, do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign rd_next = do_pop ? rd_ptr + PW'(1) : rd_ptr;

  // Storage array: no reset needed, contents are qualified by level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Head register: bypass the write when the incoming word becomes the new head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          rdata <= '0;
    else if (do_push && wr_ptr == rd_next) rdata <= wdata;
    else                                   rdata <= mem[rd_next];
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// UART echo controller: RX words are acknowledged, queued and retransmitted
// in order with a request/ack + timeout-retry TX handshake, pause control,
// sticky overflow and a pulse-stretched activity LED.
// Optional build macro: UART_ECHO_CASE_FOLD_EN (fold ASCII lower to upper on push).
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned LED_HOLD_CYCLES = 2500000,
  parameter int unsigned REQ_TIMEOUT     = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            rx_ready,
  input  logic [DATA_WIDTH-1:0]           rx_data,
  output logic                            rx_clear,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_request,
  input  logic                            tx_active,
  input  logic                            enable,
  input  logic                            overflow_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow,
  output logic                            led
);

  localparam int unsigned TMO_W = $clog2(REQ_TIMEOUT + 1);
  localparam int unsigned LED_W = $clog2(LED_HOLD_CYCLES + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_bad
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  rx_state_e             rx_state, rx_state_d;
  tx_state_e             tx_state, tx_state_d;
  logic                  rx_clear_d, tx_request_d, overflow_d;
  logic [DATA_WIDTH-1:0] tx_data_d, push_data, fifo_rdata;
  logic [TMO_W-1:0]      tmr, tmr_d;
  logic [LED_W-1:0]      led_cnt;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, drop;

`ifdef UART_ECHO_CASE_FOLD_EN
  if (DATA_WIDTH != 8) begin : g_fold_bad
    $error("UART_ECHO_CASE_FOLD_EN requires DATA_WIDTH == 8");
  end else begin : g_fold
    assign push_data = fold_case(rx_data);
  end
`else
  assign push_data = rx_data;
`endif

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (push_data),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // RX handshake: one push (or drop) per rx_ready assertion, clear held until rx_ready falls.
  always_comb begin
    rx_state_d = rx_state;
    rx_clear_d = rx_clear;
    fifo_push  = 1'b0;
    drop       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_ready) begin
          if (fifo_full) drop      = 1'b1;
          else           fifo_push = 1'b1;
          rx_clear_d = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!rx_ready) begin
          rx_clear_d = 1'b0;
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_clear_d = 1'b0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // RX state and registered clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_clear <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_clear <= rx_clear_d;
    end
  end

  // TX handshake: request the head, pop only once the transmitter answers, retry on timeout.
  always_comb begin
    tx_state_d   = tx_state;
    tx_request_d = tx_request;
    tx_data_d    = tx_data;
    tmr_d        = tmr;
    fifo_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (enable && !fifo_empty && !tx_active) begin
          tx_data_d    = fifo_rdata;
          tx_request_d = 1'b1;
          tmr_d        = '0;
          tx_state_d   = TX_REQ;
        end
      end
      TX_REQ: begin
        if (tx_active) begin
          tx_request_d = 1'b0;
          fifo_pop     = 1'b1;
          tx_state_d   = TX_BUSY;
        end else if (tmr == TMO_W'(REQ_TIMEOUT - 1)) begin
          tx_request_d = 1'b0;
          tx_state_d   = TX_IDLE;
        end else begin
          tmr_d = tmr + TMO_W'(1);
        end
      end
      TX_BUSY: begin
        if (!tx_active) tx_state_d = TX_IDLE;
      end
      default: begin
        tx_request_d = 1'b0;
        tx_state_d   = TX_IDLE;
      end
    endcase
  end

  // TX state, request, data and timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state   <= TX_IDLE;
      tx_request <= 1'b0;
      tx_data    <= '0;
      tmr        <= '0;
    end else begin
      tx_state   <= tx_state_d;
      tx_request <= tx_request_d;
      tx_data    <= tx_data_d;
      tmr        <= tmr_d;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  assign overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow);

  // Overflow flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else          overflow <= overflow_d;
  end

  // Activity LED: reload on every accepted word, lit while the countdown runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_cnt <= '0;
      led     <= 1'b0;
    end else if (fifo_push) begin
      led_cnt <= LED_W'(LED_HOLD_CYCLES);
      led     <= (LED_HOLD_CYCLES != 0);
    end else if (led_cnt != '0) begin
      led_cnt <= led_cnt - LED_W'(1);
      led     <= (led_cnt != LED_W'(1));
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: a UART transmitter model answers
// requests, an RX driver feeds words, and a queue model predicts what is sent.
module tb_uart_echo_buffer;

  localparam int DW       = 8;
  localparam int DEPTH    = 16;
  localparam int LED_HOLD = 40;
  localparam int TMO      = 1024;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_clear;
  logic [DW-1:0] tx_data;
  logic          tx_request;
  logic          tx_active = 1'b0;
  logic          enable = 1'b0;
  logic          overflow_clr = 1'b0;
  logic [4:0]    fifo_level;
  logic          overflow;
  logic          led;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_echo_buffer #(
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (DEPTH),
    .LED_HOLD_CYCLES (LED_HOLD),
    .REQ_TIMEOUT     (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_clear     (rx_clear),
    .tx_data      (tx_data),
    .tx_request   (tx_request),
    .tx_active    (tx_active),
    .enable       (enable),
    .overflow_clr (overflow_clr),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .led          (led)
  );

  // Transmitter model controls and observations.
  bit           manual = 0;
  bit           mute = 0;
  int           resp_delay = 1;
  int           resp_busy = 2;
  logic [7:0]   tx_log[$];
  int           last_run = 0;

  // Reference model: words expected on TX in order, plus expected overflow.
  logic [7:0]   exp_q[$];
  bit           mov = 0;

  typedef struct { logic [7:0] din; logic [7:0] dout; } vec_t;
  vec_t tbl[8];

  function automatic logic [7:0] mfold(input logic [7:0] d);
`ifdef UART_ECHO_CASE_FOLD_EN
    if (d >= 8'h61 && d <= 8'h7a) return d - 8'h20;
`endif
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // UART transmitter: goes busy resp_delay cycles into a request, logs the word.
  initial begin
    int rq, bz;
    rq = 0; bz = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        tx_active = 1'b0; rq = 0; bz = 0;
      end else if (manual) begin
        rq = 0;
      end else if (bz > 0) begin
        bz--;
        if (bz == 0) tx_active = 1'b0;
      end else if (tx_request && !tx_active) begin
        rq++;
        if (!mute && rq >= resp_delay) begin
          tx_active = 1'b1; bz = resp_busy; rq = 0;
          tx_log.push_back(tx_data);
        end
      end else begin
        rq = 0;
      end
    end
  end

  // Length of the most recent tx_request pulse, in cycles.
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) run = 0;
      else if (tx_request) run++;
      else if (run > 0) begin last_run = run; run = 0; end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 0; rx_ready = 0; enable = 0; overflow_clr = 0;
    manual = 0; mute = 0; tx_active = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    exp_q.delete(); tx_log.delete(); mov = 0;
  endtask

  // One full RX handshake; optionally feeds the reference model (valid while enable=0).
  task automatic send_word(input logic [7:0] d, input int hold, input bit use_model);
    int t;
    rx_data = d; rx_ready = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!rx_clear && t < 100);
    chk("rx_clear_rise_timeout", rx_clear, 1);
    repeat (hold) @(negedge clk);
    rx_ready = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (rx_clear && t < 100);
    chk("rx_clear_fall_timeout", rx_clear, 0);
    if (use_model) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(mfold(d));
      else mov = 1;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((tx_log.size() < exp_q.size() || fifo_level != 0 || tx_active || tx_request) && t < 4000) begin
      @(negedge clk); t++;
    end
    chk({name, "_drain_timeout"}, (t < 4000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_tx(input string name);
    chk({name, "_count"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      chk($sformatf("%s_word%0d", name, i), tx_log[i], exp_q[i]);
    tx_log.delete(); exp_q.delete();
  endtask

  task automatic wait_req(input string name);
    int t;
    t = 0;
    while (!tx_request && t < 100) begin @(negedge clk); t++; end
    chk({name, "_req_timeout"}, tx_request, 1);
  endtask

  initial begin
    int t, n;
    bit seen;
    logic [7:0] w;

`ifdef UART_ECHO_CASE_FOLD_EN
    tbl[0] = '{8'h61, 8'h41}; tbl[1] = '{8'h7B, 8'h7B}; tbl[2] = '{8'h5A, 8'h5A};
    tbl[3] = '{8'h7A, 8'h5A}; tbl[4] = '{8'h60, 8'h60}; tbl[5] = '{8'h6D, 8'h4D};
    tbl[6] = '{8'hE1, 8'hE1}; tbl[7] = '{8'h00, 8'h00};
`else
    tbl[0] = '{8'h61, 8'h61}; tbl[1] = '{8'h7B, 8'h7B}; tbl[2] = '{8'h5A, 8'h5A};
    tbl[3] = '{8'h7A, 8'h7A}; tbl[4] = '{8'h60, 8'h60}; tbl[5] = '{8'h6D, 8'h6D};
    tbl[6] = '{8'hE1, 8'hE1}; tbl[7] = '{8'h00, 8'h00};
`endif

    // Reset state
    #2 reset_n = 0;
    @(negedge clk);
    chk("rst_rx_clear", rx_clear, 0);
    chk("rst_tx_request", tx_request, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_led", led, 0);
    chk("rst_level", fifo_level, 0);
    reset_n = 1;
    @(negedge clk);

    // Single echo: rx_ready held 5 cycles, transmitter answers after 3 request cycles
    resp_delay = 3; resp_busy = 4; enable = 1;
    rx_data = 8'h41; rx_ready = 1;
    chk("echo_clr_pre", rx_clear, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("echo_clr_hi%0d", i), rx_clear, 1);
    end
    rx_ready = 0;
    @(negedge clk);
    chk("echo_clr_fall", rx_clear, 0);
    exp_q.push_back(8'h41);
    wait_drain("echo");
    chk("echo_req_len", last_run, 3);
    chk("echo_level", fifo_level, 0);
    chk("echo_led", led, 1);
    compare_tx("echo");
    repeat (45) @(negedge clk);
    chk("echo_led_expired", led, 0);

    // Burst with pause, overflow, LED not reloaded by drops
    do_reset();
    resp_delay = 1; resp_busy = 2;
    for (int i = 0; i < 16; i++) send_word(8'(i), $urandom_range(0, 2), 1);
    chk("burst_level16", fifo_level, 16);
    chk("burst_ovf0", overflow, 0);
    chk("burst_led_on", led, 1);
    repeat (50) @(negedge clk);
    chk("burst_led_off", led, 0);
    send_word(8'hFF, 1, 1);
    chk("burst_ovf1", overflow, 1);
    chk("burst_level_full", fifo_level, 16);
    chk("burst_led_drop", led, 0);
    overflow_clr = 1; @(negedge clk); overflow_clr = 0; @(negedge clk);
    chk("burst_ovf_clr", overflow, 0);
    // drop and clear in the same cycle: set must win
    rx_data = 8'hEE; rx_ready = 1; overflow_clr = 1;
    @(negedge clk);
    overflow_clr = 0;
    chk("burst_set_wins", overflow, 1);
    rx_ready = 0;
    repeat (2) @(negedge clk);
    chk("burst_ovf_model", overflow, mov);
    enable = 1;
    wait_drain("burst");
    compare_tx("burst");

    // Timeout and retry
    do_reset();
    mute = 1; resp_delay = 2;
    send_word(8'h55, 0, 1);
    enable = 1;
    wait_req("tmo");
    t = 0;
    while (tx_request && t < 1200) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("tmo_req_len", last_run, TMO);
    chk("tmo_no_pop", fifo_level, 1);
    chk("tmo_nothing_sent", tx_log.size(), 0);
    mute = 0;
    wait_drain("tmo");
    compare_tx("tmo");
    chk("tmo_level0", fifo_level, 0);

    // Reset while a request is outstanding
    do_reset();
    mute = 1;
    send_word(8'hAA, 0, 0);
    enable = 1;
    wait_req("rstmid");
    reset_n = 0;
    #1;
    chk("rstmid_req", tx_request, 0);
    chk("rstmid_data", tx_data, 0);
    chk("rstmid_level", fifo_level, 0);
    chk("rstmid_led", led, 0);
    chk("rstmid_clr", rx_clear, 0);
    repeat (2) @(negedge clk);
    reset_n = 1; mute = 0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (tx_request) seen = 1; end
    chk("rstmid_no_req", seen, 0);
    chk("rstmid_empty", fifo_level, 0);

    // Simultaneous push/pop at level 3, across the pointer wrap (writes 3..18)
    do_reset();
    manual = 1;
    for (int i = 0; i < 3; i++) send_word(8'h20 + 8'(i), 0, 1);
    enable = 1;
    for (int k = 0; k < 16; k++) begin
      wait_req($sformatf("pp%0d", k));
      chk($sformatf("pp_head%0d", k), tx_data, exp_q[0]);
      w = 8'h30 + 8'(k);
      rx_data = w; rx_ready = 1; tx_active = 1;
      @(negedge clk);
      void'(exp_q.pop_front());
      exp_q.push_back(w);
      chk($sformatf("pp_level%0d", k), fifo_level, 3);
      rx_ready = 0; tx_active = 0;
      @(negedge clk);
    end
    manual = 0;
    wait_drain("pp");
    compare_tx("pp");

    // Table-driven data path (case folding when enabled)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_word(tbl[i].din, 0, 0);
      exp_q.push_back(tbl[i].dout);
    end
    chk("tbl_level", fifo_level, 8);
    enable = 1;
    wait_drain("tbl");
    compare_tx("tbl");

    // Randomized batches against the queue model
    do_reset();
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 20);
      resp_delay = $urandom_range(1, 4);
      resp_busy  = $urandom_range(1, 5);
      enable = 0;
      for (int i = 0; i < n; i++) send_word(8'($urandom), $urandom_range(0, 3), 1);
      chk($sformatf("rnd%0d_level", b), fifo_level, exp_q.size());
      chk($sformatf("rnd%0d_ovf", b), overflow, mov);
      enable = 1;
      wait_drain($sformatf("rnd%0d", b));
      compare_tx($sformatf("rnd%0d", b));
      overflow_clr = 1; @(negedge clk); overflow_clr = 0; @(negedge clk);
      mov = 0;
      chk($sformatf("rnd%0d_ovf_clr", b), overflow, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
